// File: rtl/cpu_pkg.sv
// cpu_pkg: sequencer state encoding and opcode classes shared with control_matrix
package cpu_pkg;
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      FETCH     = 3'd1,
      DECODE    = 3'd2,
      EXECUTE   = 3'd3,
      MEM       = 3'd4,
      WRITEBACK = 3'd5,
      HALT      = 3'd6,
      FAULT     = 3'd7
   } state_t;
   localparam logic [3:0] OP_LOAD   = 4'b1000;
   localparam logic [3:0] OP_STORE  = 4'b1001;
   localparam logic [3:0] OP_BRANCH = 4'b1010;
   localparam logic [3:0] OP_HALT   = 4'b1111;
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts consecutive memory-wait cycles and flags the last allowed one
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic i_clock,
   input  logic i_rst,
   input  logic i_clear,
   input  logic i_count_en,
   output logic o_expired
);
   localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   logic [TW-1:0] r_cnt;
   always_ff @(posedge i_clock or posedge i_rst)
      if (i_rst) r_cnt <= '0;
      else if (i_clear) r_cnt <= '0;
      else if (i_count_en) r_cnt <= r_cnt + 1'b1;
   // a zero timeout disables faulting entirely
   assign o_expired = (MEM_TIMEOUT != 0) && i_count_en && (r_cnt == TW'(MEM_TIMEOUT - 1));
endmodule

// File: rtl/instruction_sequencer.sv
// instruction_sequencer: steps each instruction through FETCH..WRITEBACK and
// produces the state that control_matrix decodes, with run/step/halt/fault control
module instruction_sequencer
   import cpu_pkg::*;
#(
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic             clock,
   input  logic             control_reset,
   input  logic             state_machine_reset,
   input  logic             run,
   input  logic             step,
   input  logic [3:0]       opcode,
   input  logic             mem_ready,
   output logic [2:0]       state,
   output logic [3:0]       opcode_latched,
   output logic             instr_done,
   output logic             busy,
   output logic             halted,
   output logic             fault,
   output logic [CNT_W-1:0] instr_count
);
   state_t           r_state, w_next, w_after;
   logic [3:0]       r_op;
   logic [CNT_W-1:0] r_count;
   logic             w_wait, w_expired, w_end;
   assign w_wait  = (r_state == FETCH || r_state == MEM) && !mem_ready;
   assign w_after = run ? FETCH : IDLE;
   assign w_end   = (r_state == WRITEBACK) || (r_state == EXECUTE && r_op == OP_BRANCH) ||
                    (r_state == MEM && mem_ready && r_op == OP_STORE);
   mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
      .i_clock    (clock),
      .i_rst      (control_reset),
      .i_clear    (state_machine_reset || !w_wait),
      .i_count_en (w_wait),
      .o_expired  (w_expired)
   );
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:      w_next = (run || step) ? FETCH : IDLE;
         FETCH:     w_next = w_expired ? FAULT : mem_ready ? DECODE : FETCH;
         DECODE:    w_next = (opcode == OP_HALT) ? HALT : EXECUTE;
         EXECUTE:   w_next = (r_op == OP_LOAD || r_op == OP_STORE) ? MEM :
                             (r_op == OP_BRANCH) ? w_after : WRITEBACK;
         MEM:       w_next = w_expired ? FAULT : !mem_ready ? MEM :
                             (r_op == OP_LOAD) ? WRITEBACK : w_after;
         WRITEBACK: w_next = w_after;
         default:   w_next = r_state;
      endcase
   end
   always_ff @(posedge clock or posedge control_reset)
      if (control_reset) begin
         r_state <= IDLE;
         r_op    <= '0;
         r_count <= '0;
      end else begin
         r_state <= state_machine_reset ? IDLE : w_next;
         if (r_state == DECODE && !state_machine_reset) r_op <= opcode;
         if (instr_done) r_count <= r_count + 1'b1;
      end
   assign state          = r_state;
   assign opcode_latched = r_op;
   assign instr_done     = w_end && !state_machine_reset;
   assign busy           = !(r_state == IDLE || r_state == HALT || r_state == FAULT);
   assign halted         = r_state == HALT;
   assign fault          = r_state == FAULT;
   assign instr_count    = r_count;
endmodule

// File: tb/tb_instruction_sequencer.sv
// tb_instruction_sequencer: scenario tasks with a per-cycle expected-state scoreboard
module tb_instruction_sequencer;
   import cpu_pkg::*;
   localparam int CW = 4;
   localparam logic [3:0] OP_ALU = 4'b0001;
   logic          clock, control_reset, state_machine_reset, run, step, mem_ready;
   logic [3:0]    opcode, opcode_latched;
   logic [2:0]    state;
   logic          instr_done, busy, halted, fault;
   logic [CW-1:0] instr_count;
   typedef struct packed { logic [2:0] st; logic done; } exp_t;
   exp_t q[$];
   int checks = 0;
   int fails  = 0;
   instruction_sequencer #(.CNT_W(CW), .MEM_TIMEOUT(15)) dut (
      .clock               (clock),
      .control_reset       (control_reset),
      .state_machine_reset (state_machine_reset),
      .run                 (run),
      .step                (step),
      .opcode              (opcode),
      .mem_ready           (mem_ready),
      .state               (state),
      .opcode_latched      (opcode_latched),
      .instr_done          (instr_done),
      .busy                (busy),
      .halted              (halted),
      .fault               (fault),
      .instr_count         (instr_count)
   );
   initial clock = 1'b0;
   always #5 clock = ~clock;
   task automatic drive(input logic r, input logic s, input logic [3:0] op, input logic mr, input logic sr);
      @(negedge clock);
      run = r; step = s; opcode = op; mem_ready = mr; state_machine_reset = sr;
      #1;
   endtask
   task automatic test_reset();
      control_reset = 1'b1; state_machine_reset = 1'b0; run = 1'b0; step = 1'b0;
      opcode = 4'b0000; mem_ready = 1'b1;
      #3;
      checks++;
      if (state !== 3'd0 || instr_count !== '0 || opcode_latched !== 4'd0 ||
          instr_done !== 1'b0 || busy !== 1'b0 || halted !== 1'b0 || fault !== 1'b0) begin
         fails++;
         $display("FAIL reset: state=%0d count=%0d op=%h done=%b busy=%b halted=%b fault=%b, expected all zero",
                  state, instr_count, opcode_latched, instr_done, busy, halted, fault);
      end
      @(negedge clock);
      control_reset = 1'b0;
   endtask
   task automatic test_alu();
      int es [10] = '{0, 1, 2, 3, 5, 1, 2, 3, 5, 0};
      int ed [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0};
      exp_t e;
      foreach (es[i]) q.push_back(exp_t'{3'(es[i]), ed[i][0]});
      for (int i = 0; i < 10; i++) begin
         drive(i < 5, 1'b0, OP_ALU, 1'b1, 1'b0);
         e = q.pop_front();
         checks++;
         if (state !== e.st || instr_done !== e.done) begin
            fails++;
            $display("FAIL alu[%0d]: state=%0d done=%b, expected state=%0d done=%b", i, state, instr_done, e.st, e.done);
         end
         if (i == 5) begin
            checks++;
            if (instr_count !== CW'(1)) begin fails++; $display("FAIL alu_count1: got %0d, expected 1", instr_count); end
         end
      end
      checks++;
      if (instr_count !== CW'(2) || opcode_latched !== OP_ALU) begin
         fails++;
         $display("FAIL alu_end: count=%0d op=%h, expected count=2 op=%h", instr_count, opcode_latched, OP_ALU);
      end
   endtask
   task automatic test_load_store();
      int es [14] = '{0, 1, 2, 3, 4, 5, 1, 2, 3, 4, 4, 4, 4, 0};
      int ed [14] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0};
      exp_t e;
      foreach (es[i]) q.push_back(exp_t'{3'(es[i]), ed[i][0]});
      for (int i = 0; i < 14; i++) begin
         drive(i < 6, 1'b0, i < 5 ? OP_LOAD : i < 8 ? OP_STORE : OP_ALU, !(i >= 9 && i <= 11), 1'b0);
         e = q.pop_front();
         checks++;
         if (state !== e.st || instr_done !== e.done) begin
            fails++;
            $display("FAIL ldst[%0d]: state=%0d done=%b, expected state=%0d done=%b", i, state, instr_done, e.st, e.done);
         end
      end
      checks++;
      if (instr_count !== CW'(4) || opcode_latched !== OP_STORE) begin
         fails++;
         $display("FAIL ldst_end: count=%0d op=%h, expected count=4 op=%h", instr_count, opcode_latched, OP_STORE);
      end
   endtask
   task automatic test_halt();
      int es [10] = '{0, 1, 2, 3, 1, 2, 6, 6, 6, 0};
      int ed [10] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
      exp_t e;
      foreach (es[i]) q.push_back(exp_t'{3'(es[i]), ed[i][0]});
      for (int i = 0; i < 10; i++) begin
         drive(i < 8, 1'b0, i < 3 ? OP_BRANCH : OP_HALT, 1'b1, i == 8);
         e = q.pop_front();
         checks++;
         if (state !== e.st || instr_done !== e.done) begin
            fails++;
            $display("FAIL halt[%0d]: state=%0d done=%b, expected state=%0d done=%b", i, state, instr_done, e.st, e.done);
         end
         if (i == 6) begin
            checks++;
            if (halted !== 1'b1 || busy !== 1'b0 || fault !== 1'b0) begin
               fails++;
               $display("FAIL halt_flags: halted=%b busy=%b fault=%b, expected 1 0 0", halted, busy, fault);
            end
         end
      end
      checks++;
      if (instr_count !== CW'(5) || halted !== 1'b0) begin
         fails++;
         $display("FAIL halt_end: count=%0d halted=%b, expected count=5 halted=0", instr_count, halted);
      end
   endtask
   task automatic test_timeout();
      exp_t e;
      for (int i = 0; i < 20; i++)
         q.push_back(exp_t'{i == 0 ? 3'd0 : i <= 15 ? 3'd1 : i == 16 ? 3'd2 : i == 17 ? 3'd3 : i == 18 ? 3'd5 : 3'd0, i == 18});
      for (int i = 0; i < 20; i++) begin
         drive(i == 0, 1'b0, OP_ALU, !(i >= 1 && i <= 14), 1'b0);
         e = q.pop_front();
         checks++;
         if (state !== e.st || instr_done !== e.done) begin
            fails++;
            $display("FAIL wait14[%0d]: state=%0d done=%b, expected state=%0d done=%b", i, state, instr_done, e.st, e.done);
         end
      end
      checks++;
      if (fault !== 1'b0 || instr_count !== CW'(6)) begin
         fails++;
         $display("FAIL wait14_end: fault=%b count=%0d, expected fault=0 count=6", fault, instr_count);
      end
      for (int i = 0; i < 20; i++)
         q.push_back(exp_t'{i == 0 ? 3'd0 : i <= 15 ? 3'd1 : i <= 18 ? 3'd7 : 3'd0, 1'b0});
      for (int i = 0; i < 20; i++) begin
         drive(i == 0 || i == 17, 1'b0, OP_ALU, !(i >= 1 && i <= 16), i == 18);
         e = q.pop_front();
         checks++;
         if (state !== e.st || instr_done !== e.done) begin
            fails++;
            $display("FAIL wait15[%0d]: state=%0d done=%b, expected state=%0d done=%b", i, state, instr_done, e.st, e.done);
         end
         if (i == 17) begin
            checks++;
            if (fault !== 1'b1 || busy !== 1'b0) begin
               fails++;
               $display("FAIL fault_flags: fault=%b busy=%b, expected 1 0", fault, busy);
            end
         end
      end
      checks++;
      if (instr_count !== CW'(6)) begin fails++; $display("FAIL fault_count: got %0d, expected 6", instr_count); end
   endtask
   task automatic test_step_wrap();
      int es [7] = '{0, 1, 2, 3, 5, 0, 0};
      exp_t e;
      foreach (es[i]) q.push_back(exp_t'{3'(es[i]), i == 4});
      for (int i = 0; i < 7; i++) begin
         drive(1'b0, i == 0 || i == 2, OP_ALU, 1'b1, 1'b0);
         e = q.pop_front();
         checks++;
         if (state !== e.st || instr_done !== e.done) begin
            fails++;
            $display("FAIL step[%0d]: state=%0d done=%b, expected state=%0d done=%b", i, state, instr_done, e.st, e.done);
         end
      end
      checks++;
      if (instr_count !== CW'(7)) begin fails++; $display("FAIL step_count: got %0d, expected 7", instr_count); end
      for (int k = 0; k < 9; k++)
         for (int j = 0; j < 4; j++) q.push_back(exp_t'{3'(j), j == 3});
      q.push_back(exp_t'{3'd0, 1'b0});
      for (int i = 0; i < 37; i++) begin
         drive(1'b0, i % 4 == 0 && i < 36, OP_BRANCH, 1'b1, 1'b0);
         e = q.pop_front();
         checks++;
         if (state !== e.st || instr_done !== e.done) begin
            fails++;
            $display("FAIL wrap[%0d]: state=%0d done=%b, expected state=%0d done=%b", i, state, instr_done, e.st, e.done);
         end
         if (i == 32) begin
            checks++;
            if (instr_count !== CW'(15)) begin fails++; $display("FAIL wrap_max: got %0d, expected 15", instr_count); end
         end
      end
      checks++;
      if (instr_count !== CW'(0)) begin fails++; $display("FAIL wrap_zero: got %0d, expected 0", instr_count); end
   endtask
   task automatic test_async_reset();
      int es [7] = '{0, 1, 2, 3, 1, 2, 3};
      exp_t e;
      foreach (es[i]) q.push_back(exp_t'{3'(es[i]), i == 3});
      for (int i = 0; i < 7; i++) begin
         drive(1'b1, 1'b0, i < 3 ? OP_BRANCH : OP_ALU, 1'b1, 1'b0);
         e = q.pop_front();
         checks++;
         if (state !== e.st || instr_done !== e.done) begin
            fails++;
            $display("FAIL arst_seq[%0d]: state=%0d done=%b, expected state=%0d done=%b", i, state, instr_done, e.st, e.done);
         end
      end
      checks++;
      if (instr_count !== CW'(1)) begin fails++; $display("FAIL arst_pre: count=%0d, expected 1", instr_count); end
      #1 control_reset = 1'b1;
      #1;
      checks++;
      if (state !== 3'd0 || instr_count !== '0 || opcode_latched !== 4'd0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL arst: state=%0d count=%0d op=%h busy=%b, expected 0 0 0 0", state, instr_count, opcode_latched, busy);
      end
      run = 1'b0;
      @(negedge clock);
      control_reset = 1'b0;
   endtask
   initial begin
      test_reset();
      test_alu();
      test_load_store();
      test_halt();
      test_timeout();
      test_step_wrap();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
